// File: rtl/minmax_tracker_pkg.sv
// Shared types and constants for the min/max frame tracker.
package minmax_tracker_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned MAX_FRAME_LEN = 256;
    localparam int unsigned CNT_W         = $clog2(MAX_FRAME_LEN + 1);
    localparam int unsigned IDX_W         = $clog2(MAX_FRAME_LEN);

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/minmax_tracker_sign_cmp16.sv
// Signed 16-bit magnitude comparator: flags a < b and a > b.
module sign_cmp16
    import minmax_tracker_pkg::*;
(
    input  sample_t a_i,
    input  sample_t b_i,
    output logic    lt_o,
    output logic    gt_o
);

    always_comb begin
        lt_o = (a_i < b_i);
        gt_o = (a_i > b_i);
    end

endmodule

// File: rtl/minmax_tracker.sv
// Tracks signed min/max (and optionally their positions) over frames of samples.
// Position tracking is compiled in only when MINMAX_TRACKER_IDX_EN is defined.
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  sample_t          in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output sample_t          out_min,
    output sample_t          out_max,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] FrameLenC = CNT_W'(FRAME_LEN);

    state_e           state_q, state_d;
    sample_t          min_q, min_d;
    sample_t          max_q, max_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    logic             accept;
    logic             min_lt, min_gt_unused;
    logic             max_lt_unused, max_gt;

    sign_cmp16 u_cmp_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .lt_o (min_lt),
        .gt_o (min_gt_unused)
    );

    sign_cmp16 u_cmp_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .lt_o (max_lt_unused),
        .gt_o (max_gt)
    );

    // ready_q holds in_ready low until the first edge after reset release.
    assign in_ready  = ready_q && (state_q != StDone);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = CNT_W'(1);
                    state_d = (in_last || FrameLenC == CNT_W'(1)) ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    if (min_lt) min_d = in_data;
                    if (max_gt) max_d = in_data;
                    count_d = count_q + CNT_W'(1);
                    if (in_last || count_d == FrameLenC) state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            ready_q <= 1'b1;
        end
    end

`ifdef MINMAX_TRACKER_IDX_EN
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;

    // Position of the incoming sample equals the count before it is accepted.
    always_comb begin
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        if (accept) begin
            if (state_q == StIdle) begin
                min_idx_d = '0;
                max_idx_d = '0;
            end else begin
                if (min_lt) min_idx_d = count_q[IDX_W-1:0];
                if (max_gt) max_idx_d = count_q[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
`else
    assign out_min_idx = '0;
    assign out_max_idx = '0;
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Randomized self-checking bench for minmax_tracker against a frame-level reference model.
module tb_minmax_tracker;
    import minmax_tracker_pkg::*;

`ifdef MINMAX_TRACKER_IDX_EN
    localparam bit IdxEn = 1'b1;
`else
    localparam bit IdxEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic             in_valid, in_ready, in_last, out_valid, out_ready;
    sample_t          in_data, out_min, out_max;
    logic [IDX_W-1:0] out_min_idx, out_max_idx;
    logic [CNT_W-1:0] out_count;

    logic             in_valid_1, in_ready_1, in_last_1, out_valid_1, out_ready_1;
    sample_t          in_data_1, out_min_1, out_max_1;
    logic [IDX_W-1:0] out_min_idx_1, out_max_idx_1;
    logic [CNT_W-1:0] out_count_1;

    minmax_tracker #(.FRAME_LEN(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx),
        .out_count   (out_count)
    );

    minmax_tracker #(.FRAME_LEN(1)) dut_len1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid_1),
        .in_ready    (in_ready_1),
        .in_data     (in_data_1),
        .in_last     (in_last_1),
        .out_valid   (out_valid_1),
        .out_ready   (out_ready_1),
        .out_min     (out_min_1),
        .out_max     (out_max_1),
        .out_min_idx (out_min_idx_1),
        .out_max_idx (out_max_idx_1),
        .out_count   (out_count_1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        sample_t mn;
        sample_t mx;
        int      mn_i;
        int      mx_i;
        int      cnt;
    } res_t;

    // Frame result from first principles: extremes, then first position holding each.
    function automatic res_t model(input sample_t s[$]);
        res_t r;
        r.mn = s[0];
        r.mx = s[0];
        foreach (s[i]) begin
            if (s[i] < r.mn) r.mn = s[i];
            if (s[i] > r.mx) r.mx = s[i];
        end
        r.mn_i = -1;
        r.mx_i = -1;
        foreach (s[i]) begin
            if (r.mn_i < 0 && s[i] == r.mn) r.mn_i = i;
            if (r.mx_i < 0 && s[i] == r.mx) r.mx_i = i;
        end
        if (!IdxEn) begin
            r.mn_i = 0;
            r.mx_i = 0;
        end
        r.cnt = s.size();
        return r;
    endfunction

    task automatic check_result(input string tag, input res_t e);
        check_eq({tag, "_min"}, out_min, e.mn);
        check_eq({tag, "_max"}, out_max, e.mx);
        check_eq({tag, "_min_idx"}, out_min_idx, e.mn_i);
        check_eq({tag, "_max_idx"}, out_max_idx, e.mx_i);
        check_eq({tag, "_count"}, out_count, e.cnt);
    endtask

    // hold < 0 picks a random stall length on the result handshake.
    task automatic run_frame(input string tag, input sample_t s[$], input bit use_last,
                             input int hold);
        res_t e;
        int   n_hold;
        e = model(s);
        for (int i = 0; i < s.size(); i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = use_last && (i == s.size() - 1);
            check_eq({tag, "_in_ready"}, in_ready, 1);
            check_eq({tag, "_early_valid"}, out_valid, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq({tag, "_out_valid"}, out_valid, 1);
        check_result(tag, e);

        n_hold = (hold < 0) ? int'($urandom_range(0, 4)) : hold;
        out_ready = 1'b0;
        for (int k = 0; k < n_hold; k++) begin
            in_valid = 1'b1;
            in_data  = sample_t'($urandom);
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_in_ready"}, in_ready, 0);
            check_result({tag, "_hold"}, e);
        end
        // A sample offered during the output handshake must be ignored.
        in_valid  = 1'b1;
        in_data   = sample_t'($urandom);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq({tag, "_ret_valid"}, out_valid, 0);
        check_eq({tag, "_ret_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sample_t q[$];
        int      len;
        bit      lst;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        in_valid_1 = 1'b0; in_data_1 = '0; in_last_1 = 1'b0; out_ready_1 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_min", out_min, 0);
        check_eq("rst_max", out_max, 0);
        check_eq("rst_count", out_count, 0);
        check_eq("rst_min_idx", out_min_idx, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready_pre_edge", in_ready, 0);
        @(negedge clk);
        check_eq("rel_in_ready_post_edge", in_ready, 1);

        q = '{16'sd3, -16'sd5, 16'sd7, 16'sd7, -16'sd5, 16'sd0, 16'sd1, 16'sd2};
        run_frame("full8", q, 1'b0, 0);

        q = '{16'sd4, 16'sh8000, -16'sd1, 16'sh7FFF, 16'sd0};
        run_frame("extremes", q, 1'b1, 1);

        q = '{16'sd10, 16'sd20, 16'sd5};
        run_frame("last3", q, 1'b1, 5);

        q = '{16'sd9};
        run_frame("last1", q, 1'b1, 0);

        // Reset mid-frame: partial frame is discarded.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = sample_t'(i * 100 - 150);
            @(negedge clk);
            check_eq("partial_no_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_count", out_count, 0);
        check_eq("midrst_min", out_min, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_no_valid", out_valid, 0);
        q = '{-16'sd8, 16'sd6, 16'sd6, -16'sd8, 16'sd100, 16'sd3, -16'sd200, 16'sd100};
        run_frame("after_rst", q, 1'b0, -1);

        for (int f = 0; f < 40; f++) begin
            q.delete();
            len = $urandom_range(1, 8);
            lst = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) q.push_back(sample_t'($signed($urandom_range(0, 4)) - 2));
                else if ($urandom_range(0, 7) == 0) q.push_back(($urandom_range(0, 1) == 0) ? 16'sh8000 : 16'sh7FFF);
                else q.push_back(sample_t'($urandom));
            end
            run_frame("rand", q, lst, -1);
        end

        in_valid_1 = 1'b1;
        in_data_1  = -16'sd1;
        check_eq("len1_in_ready", in_ready_1, 1);
        @(negedge clk);
        in_valid_1 = 1'b0;
        check_eq("len1_out_valid", out_valid_1, 1);
        check_eq("len1_min", out_min_1, 32'hFFFF_FFFF);
        check_eq("len1_max", out_max_1, 32'hFFFF_FFFF);
        check_eq("len1_count", out_count_1, 1);
        check_eq("len1_min_idx", out_min_idx_1, 0);
        check_eq("len1_max_idx", out_max_idx_1, 0);
        out_ready_1 = 1'b1;
        @(negedge clk);
        out_ready_1 = 1'b0;
        check_eq("len1_ret_valid", out_valid_1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
